// File: rtl/wb_serial_master_if.sv
// if_wb: point-to-point Wishbone classic bundle,
// 32-bit address and data, byte selects.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_o,
    input  ack, dat_i
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_o,
    output ack, dat_i
  );
endinterface

// File: rtl/wb_serial_master.sv
// wb_serial_master: replays framed serial commands as
// big-endian full-word Wishbone classic master cycles.
module wb_serial_master #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  if_wb.master       bus,
  output logic       busy
);

  localparam logic [7:0] C_W = 8'h57;
  localparam logic [7:0] C_R = 8'h52;
  localparam logic [7:0] C_P = 8'h50;
  localparam logic [7:0] C_K = 8'h4B;
  localparam logic [7:0] C_Q = 8'h3F;
  localparam logic [7:0] C_T = 8'h54;

  localparam int TW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST =
    (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_cnt;
  logic [31:0]   r_adr;
  logic [31:0]   r_dat;
  logic [31:0]   r_rdat;
  logic          r_we;
  logic          r_cyc;
  logic          r_rd;
  logic [3:0]    r_sel;
  logic [7:0]    r_resp;
  logic [TW-1:0] r_to;

  logic          w_rx_fire;
  logic          w_tx_fire;
  logic          w_last;
  logic          w_expire;
  logic [31:0]   w_rsh;

  assign rx_ready = (r_state == S_CMD)
                 || (r_state == S_ADDR)
                 || (r_state == S_DATA);
  assign busy     = (r_state != S_CMD);
  assign tx_valid = (r_state == S_RESP);

  assign w_rx_fire = rx_valid & rx_ready;
  assign w_tx_fire = tx_valid & tx_ready;
  assign w_last    = (r_cnt == 2'd3);
  assign w_expire  = (TIMEOUT != 0)
                  && (r_to == TO_LAST);

  // read reply walks the captured word MSB first
  assign w_rsh   = r_rdat << {r_cnt, 3'b000};
  assign tx_data = !tx_valid ? 8'h00
                 : r_rd      ? w_rsh[31:24]
                 :             r_resp;

  assign bus.cyc   = r_cyc;
  assign bus.stb   = r_cyc;
  assign bus.we    = r_we;
  assign bus.sel   = r_sel;
  assign bus.adr   = r_adr;
  assign bus.dat_o = r_dat;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_CMD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CMD: begin
        if (w_rx_fire) begin
          if (rx_data == C_W || rx_data == C_R)
            w_next = S_ADDR;
          else
            w_next = S_RESP;
        end
      end
      S_ADDR: begin
        if (w_rx_fire && w_last)
          w_next = r_we ? S_DATA : S_BUS;
      end
      S_DATA: begin
        if (w_rx_fire && w_last)
          w_next = S_BUS;
      end
      S_BUS: begin
        if (bus.ack || w_expire)
          w_next = S_RESP;
      end
      S_RESP: begin
        if (w_tx_fire && (!r_rd || w_last))
          w_next = S_CMD;
      end
      default: w_next = S_CMD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt  <= 2'd0;
      r_adr  <= 32'h0;
      r_dat  <= 32'h0;
      r_rdat <= 32'h0;
      r_we   <= 1'b0;
      r_cyc  <= 1'b0;
      r_rd   <= 1'b0;
      r_sel  <= 4'h0;
      r_resp <= 8'h00;
      r_to   <= '0;
    end else begin
      unique case (r_state)
        S_CMD: begin
          if (w_rx_fire) begin
            r_cnt  <= 2'd0;
            r_rd   <= 1'b0;
            r_we   <= (rx_data == C_W);
            r_resp <= (rx_data == C_P) ? C_K : C_Q;
          end
        end
        S_ADDR: begin
          if (w_rx_fire) begin
            r_adr <= {r_adr[23:0], rx_data};
            r_cnt <= r_cnt + 2'd1;
            if (w_last && !r_we) begin
              r_cyc <= 1'b1;
              r_sel <= 4'hF;
              r_to  <= '0;
            end
          end
        end
        S_DATA: begin
          if (w_rx_fire) begin
            r_dat <= {r_dat[23:0], rx_data};
            r_cnt <= r_cnt + 2'd1;
            if (w_last) begin
              r_cyc <= 1'b1;
              r_sel <= 4'hF;
              r_to  <= '0;
            end
          end
        end
        S_BUS: begin
          // ack outranks a same-cycle terminal count
          if (bus.ack) begin
            r_cyc  <= 1'b0;
            r_rd   <= !r_we;
            r_resp <= C_K;
            if (!r_we) r_rdat <= bus.dat_i;
          end else if (w_expire) begin
            r_cyc  <= 1'b0;
            r_resp <= C_T;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        S_RESP: begin
          if (w_tx_fire) r_cnt <= r_cnt + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_serial_master.sv
// tb_wb_serial_master: random command frames against a
// frame-level reply model, with a scripted Wishbone slave.
module tb_wb_serial_master;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  always #5 clk = ~clk;

  if_wb bus_if ();

  wb_serial_master #(.TIMEOUT(TO)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus      (bus_if),
    .busy     (busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdat;
    int          dly;
  } plan_t;

  plan_t       plans[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  got_tx[$];
  logic [7:0]  last_got[4];
  int          last_n;
  int          checks = 0;
  int          failures = 0;
  int          tx_mode = 0;
  int          stall = 0;
  int          cyc_cycles = 0;
  logic [31:0] cap_adr;
  logic [31:0] cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;
  logic        sl_active = 1'b0;
  int          sl_cnt = 0;
  plan_t       sl_p;
  logic        prev_txv = 1'b0;
  logic        prev_acc = 1'b0;
  logic [7:0]  prev_txd = 8'h00;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Slave, transmitter and per-cycle output checks.
  task automatic mon();
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        sl_active = 1'b0;
        bus_if.ack = 1'b0;
        bus_if.dat_i = 32'h0;
        tx_ready = 1'b0;
        prev_txv = 1'b0;
        prev_acc = 1'b0;
        stall = 0;
      end else begin
        if (prev_txv && !prev_acc) begin
          chk("tx_valid_held", tx_valid, 1);
          chk("tx_data_held", tx_data, prev_txd);
        end
        if (tx_valid) begin
          chk("rx_ready_resp", rx_ready, 0);
          chk("busy_resp", busy, 1);
        end
        if (bus_if.ack) begin
          bus_if.ack = 1'b0;
          sl_active = 1'b0;
          chk("cyc_drop_ack", bus_if.cyc, 0);
        end else if (sl_active && !bus_if.cyc) begin
          sl_active = 1'b0;
          chk("timeout_due", sl_p.dly >= TO, 1);
          chk("timeout_len", sl_cnt, TO);
        end
        if (bus_if.cyc && !sl_active) begin
          chk("cycle_planned", plans.size() != 0, 1);
          if (plans.size() != 0)
            sl_p = plans.pop_front();
          else
            sl_p = '{1'b0, 32'h0, 32'h0, 32'h0, 1000};
          sl_active = 1'b1;
          sl_cnt = 0;
        end
        if (bus_if.cyc) begin
          cyc_cycles++;
          chk("stb", bus_if.stb, 1);
          chk("adr", bus_if.adr, sl_p.adr);
          chk("we", bus_if.we, sl_p.we);
          chk("sel", bus_if.sel, 4'hF);
          if (sl_p.we)
            chk("dat_o", bus_if.dat_o, sl_p.dat);
          chk("rx_ready_bus", rx_ready, 0);
          chk("busy_bus", busy, 1);
          if (sl_cnt == sl_p.dly) begin
            bus_if.ack = 1'b1;
            bus_if.dat_i = sl_p.rdat;
            cap_adr = bus_if.adr;
            cap_dat = bus_if.dat_o;
            cap_we = bus_if.we;
            cap_sel = bus_if.sel;
          end else begin
            bus_if.dat_i = $urandom;
          end
          sl_cnt++;
        end
        if (tx_mode == 0) begin
          tx_ready = ($urandom_range(0, 3) != 0);
        end else if (tx_valid) begin
          if (stall < 5) begin
            tx_ready = 1'b0;
            stall++;
          end else begin
            tx_ready = 1'b1;
            stall = 0;
          end
        end else begin
          tx_ready = 1'b0;
        end
        prev_txv = tx_valid;
        prev_txd = tx_data;
        prev_acc = tx_valid && tx_ready;
        if (prev_acc) got_tx.push_back(tx_data);
      end
    end
  endtask

  // Frame-level reply rules.
  task automatic model_reply(input logic [7:0] cmd,
                             input logic [31:0] rdat,
                             input int dly);
    if (cmd == 8'h57 || cmd == 8'h52) begin
      if (dly >= TO)
        exp_tx.push_back(8'h54);
      else if (cmd == 8'h57)
        exp_tx.push_back(8'h4B);
      else
        for (int i = 3; i >= 0; i--)
          exp_tx.push_back(rdat[8*i +: 8]);
    end else if (cmd == 8'h50) begin
      exp_tx.push_back(8'h4B);
    end else begin
      exp_tx.push_back(8'h3F);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept", rx_ready, 1);
    @(posedge clk);
  endtask

  task automatic run_frame(input logic [7:0] cmd,
                           input logic [31:0] adr,
                           input logic [31:0] dat,
                           input logic [31:0] rdat,
                           input int dly,
                           input bit reply);
    plan_t p;
    bit wr;
    bit rd;
    wr = (cmd == 8'h57);
    rd = (cmd == 8'h52);
    if (wr || rd) begin
      p = '{wr, adr, dat, rdat, dly};
      plans.push_back(p);
    end
    if (reply) model_reply(cmd, rdat, dly);
    send_byte(cmd);
    if (wr || rd)
      for (int i = 3; i >= 0; i--)
        send_byte(adr[8*i +: 8]);
    if (wr)
      for (int i = 3; i >= 0; i--)
        send_byte(dat[8*i +: 8]);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((got_tx.size() < exp_tx.size() || busy)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, n < 3000, 1);
    repeat (2) @(negedge clk);
    chk({nm, "_count"}, got_tx.size(), exp_tx.size());
    for (int i = 0; i < got_tx.size()
         && i < exp_tx.size(); i++)
      chk({nm, "_byte"}, got_tx[i], exp_tx[i]);
    last_n = got_tx.size();
    for (int i = 0; i < 4; i++)
      last_got[i] = (i < got_tx.size()) ? got_tx[i] : 8'h00;
    got_tx.delete();
    exp_tx.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int dly;
    int n;
    int cyc0;
    logic [7:0] c;

    rst_i = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_ready = 1'b0;
    bus_if.ack = 1'b0;
    bus_if.dat_i = 32'h0;
    fork
      mon();
    join_none
    #1;
    chk("rst_cyc", bus_if.cyc, 0);
    chk("rst_stb", bus_if.stb, 0);
    chk("rst_we", bus_if.we, 0);
    chk("rst_sel", bus_if.sel, 0);
    chk("rst_adr", bus_if.adr, 0);
    chk("rst_dat_o", bus_if.dat_o, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rel_rx_ready", rx_ready, 1);
    chk("rel_busy", busy, 0);

    run_frame(8'h57, 32'h10, 32'hDEADBEEF, 32'h0, 2, 1);
    drain("t1");
    chk("t1_n", last_n, 1);
    chk("t1_k", last_got[0], 8'h4B);
    chk("t1_adr", cap_adr, 32'h10);
    chk("t1_we", cap_we, 1);
    chk("t1_dat", cap_dat, 32'hDEADBEEF);
    chk("t1_sel", cap_sel, 4'hF);

    run_frame(8'h52, 32'h10, 32'h0, 32'hCAFEF00D, 1, 1);
    drain("t2");
    chk("t2_n", last_n, 4);
    chk("t2_b0", last_got[0], 8'hCA);
    chk("t2_b1", last_got[1], 8'hFE);
    chk("t2_b2", last_got[2], 8'hF0);
    chk("t2_b3", last_got[3], 8'h0D);
    chk("t2_we", cap_we, 0);
    chk("t2_busy", busy, 0);

    run_frame(8'h52, 32'h30000000, 32'h0, 32'h0, 1000, 1);
    drain("t3");
    chk("t3_t", last_got[0], 8'h54);
    run_frame(8'h50, 32'h0, 32'h0, 32'h0, 0, 1);
    drain("t3p");
    chk("t3p_k", last_got[0], 8'h4B);

    cyc0 = cyc_cycles;
    run_frame(8'h41, 32'h0, 32'h0, 32'h0, 0, 1);
    drain("t4");
    chk("t4_q", last_got[0], 8'h3F);
    chk("t4_nocyc", cyc_cycles, cyc0);
    run_frame(8'h50, 32'h0, 32'h0, 32'h0, 0, 1);
    drain("t4p");
    chk("t4p_k", last_got[0], 8'h4B);

    run_frame(8'h57, 32'h20, 32'h1, 32'h0, TO - 1, 1);
    drain("ack_at_limit");
    chk("limit_k", last_got[0], 8'h4B);

    tx_mode = 1;
    run_frame(8'h52, 32'h44, 32'h0, $urandom, 3, 1);
    drain("t5");
    tx_mode = 0;

    run_frame(8'h52, 32'h40, 32'h0, 32'h12345678, 1000, 0);
    n = 0;
    while (!bus_if.cyc && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("t6_cyc_up", bus_if.cyc, 1);
    #2 rst_i = 1'b0;
    #1;
    chk("t6_cyc", bus_if.cyc, 0);
    chk("t6_stb", bus_if.stb, 0);
    chk("t6_tx_valid", tx_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_adr", bus_if.adr, 0);
    @(negedge clk);
    #2 rst_i = 1'b1;
    @(negedge clk);
    chk("t6_rx_ready", rx_ready, 1);
    chk("t6_busy_rel", busy, 0);
    got_tx.delete();
    exp_tx.delete();
    run_frame(8'h50, 32'h0, 32'h0, 32'h0, 0, 1);
    drain("t6p");
    chk("t6p_k", last_got[0], 8'h4B);

    for (int f = 0; f < 80; f++) begin
      k = $urandom_range(0, 9);
      if (k < 4) begin
        c = 8'h57;
      end else if (k < 7) begin
        c = 8'h52;
      end else if (k < 8) begin
        c = 8'h50;
      end else begin
        c = 8'($urandom);
        while (c == 8'h57 || c == 8'h52 || c == 8'h50)
          c = 8'($urandom);
      end
      if ($urandom_range(0, 4) == 0)
        dly = $urandom_range(TO - 1, TO + 3);
      else
        dly = $urandom_range(0, 6);
      run_frame(c, $urandom, $urandom, $urandom, dly, 1);
      if (f % 4 == 3) drain("rand");
    end
    drain("rand_tail");
    chk("plans_left", plans.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
